// File: rtl/grid_arbiter.sv
// grid_arbiter: round-robin sequencer sharing one registered-read grid RAM
// port among NREQ placement engines (read, write, atomic claim).
module grid_arbiter #(
    parameter int NREQ = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] EMPTY = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_ok,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLAIM = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  idx;
    logic              any_req;
    logic [1:0]        win_op;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NREQ-1:0]   win_oh;
    logic [NREQ-1:0]   owner_oh;
    logic              mem_write_q;
    logic              claim_wr;

    // First pending requester after the last winner, wrapping around.
    always_comb begin
        any_req = 1'b0;
        win     = ptr;
        idx     = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        win_op   = OP_READ;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PTR_W'(i)) begin
                win_op   = req_op[2*i +: 2];
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign win_oh   = NREQ'(1) << win;
    assign owner_oh = NREQ'(1) << owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_READ;
            ptr         <= PTR_W'(NREQ - 1);
            owner       <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_ok      <= 1'b0;
            mem_read    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            req_ready   <= '0;
            rsp_valid   <= '0;
            mem_read    <= 1'b0;
            mem_write_q <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (any_req) begin
                        state       <= S_ISSUE;
                        ptr         <= win;
                        owner       <= win;
                        op_q        <= win_op;
                        req_ready   <= win_oh;
                        mem_addr    <= win_addr;
                        mem_wdata   <= win_data;
                        mem_read    <= (win_op == OP_READ) ||
                                       (win_op == OP_CLAIM);
                        mem_write_q <= (win_op == OP_WRITE);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    unique case (op_q)
                        OP_READ, OP_CLAIM: state <= S_DATA;
                        OP_WRITE, OP_RSVD: begin
                            state     <= S_DONE;
                            rsp_valid <= owner_oh;
                            rsp_data  <= '0;
                            rsp_ok    <= (op_q == OP_WRITE);
                        end
                    endcase
                end
                S_DATA: begin
                    state     <= S_DONE;
                    rsp_valid <= owner_oh;
                    rsp_data  <= mem_rdata;
                    rsp_ok    <= (op_q == OP_READ) ||
                                 (mem_rdata == EMPTY);
                end
            endcase
        end
    end

    // Claim write must see this cycle's read data, so it bypasses the
    // output register; the state gate lets reset cancel it at once.
    assign claim_wr  = (state == S_DATA) && (op_q == OP_CLAIM) &&
                       (mem_rdata == EMPTY);
    assign mem_write = mem_write_q | claim_wr;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_grid_arbiter.sv
// tb_grid_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the shared grid RAM.
module tb_grid_arbiter;

    localparam int NREQ = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLAIM = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] data;
        logic        ok;
    } ev_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [2*NREQ-1:0]      req_op = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_ok;
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata = '0;
    logic                   busy;

    int pass_n = 0;
    int total_n = 0;
    int cyc = 0;

    logic [31:0] ram [4096];
    logic [31:0] mram [4096];
    logic        pl_en = 1'b0;
    logic        pl_clr = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    ev_t gq[$];
    ev_t rq[$];
    ev_t rdq[$];
    ev_t wrq[$];

    grid_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .EMPTY(EMPTY)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_ok(rsp_ok),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM with a bench-side preload port.
    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= EMPTY;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_read) mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) gq.push_back('{cyc, i, 32'd0, 1'b0});
                if (rsp_valid[i]) rq.push_back('{cyc, i, rsp_data, rsp_ok});
            end
            if (mem_read) rdq.push_back('{cyc, int'(mem_addr), 32'd0, 1'b0});
            if (mem_write) wrq.push_back('{cyc, int'(mem_addr), mem_wdata, 1'b0});
        end
    end

    function automatic ev_t at(input ev_t q[$], input int k);
        if (k < q.size()) return q[k];
        return '{-1, -1, 32'd0, 1'b0};
    endfunction

    task automatic clear_logs();
        gq.delete(); rq.delete(); rdq.delete(); wrq.delete();
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input int a, input logic [31:0] d);
        req_op[2*i +: 2] = op;
        req_addr[i*ADDR_W +: ADDR_W] = a[11:0];
        req_data[i*DATA_W +: DATA_W] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = req_valid & ~req_ready;
        end
    endtask

    task automatic ram_set(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a[11:0]; pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic ram_clear();
        @(negedge clk);
        pl_clr = 1'b1;
        @(negedge clk);
        pl_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_n++;
        if ({req_ready, rsp_valid, mem_read, mem_write, busy} !== '0)
            $display("FAIL reset_strobes: got %b want 0",
                     {req_ready, rsp_valid, mem_read, mem_write, busy});
        else pass_n++;
        total_n++;
        if (rsp_data !== 32'd0 || rsp_ok !== 1'b0)
            $display("FAIL reset_rsp: got data=%h ok=%b want 0/0",
                     rsp_data, rsp_ok);
        else pass_n++;
        total_n++;
        if (mem_addr !== 12'd0 || mem_wdata !== 32'd0)
            $display("FAIL reset_mem: got addr=%h wdata=%h want 0/0",
                     mem_addr, mem_wdata);
        else pass_n++;
        reset = 1'b0;
        ram_clear();
    endtask

    task automatic test_single_read();
        int c0;
        ev_t g, r, m;
        ram_set(12'h005, 32'd7);
        @(negedge clk);
        clear_logs(); c0 = cyc;
        set_req(2, OP_READ, 12'h005, 32'd0);
        run(5);
        g = at(gq, 0); r = at(rq, 0); m = at(rdq, 0);
        total_n++;
        if (gq.size() != 1 || g.idx != 2 || g.cyc - c0 != 1)
            $display("FAIL read_grant: got n=%0d idx=%0d cyc=%0d want 1/2/1",
                     gq.size(), g.idx, g.cyc - c0);
        else pass_n++;
        total_n++;
        if (rdq.size() != 1 || m.idx != 5 || m.cyc - c0 != 1 || wrq.size() != 0)
            $display("FAIL read_strobe: got n=%0d addr=%0d cyc=%0d wr=%0d want 1/5/1/0",
                     rdq.size(), m.idx, m.cyc - c0, wrq.size());
        else pass_n++;
        total_n++;
        if (rq.size() != 1 || r.idx != 2 || r.cyc - c0 != 3 ||
            r.data !== 32'd7 || r.ok !== 1'b1)
            $display("FAIL read_rsp: got n=%0d idx=%0d cyc=%0d data=%h ok=%b want 1/2/3/7/1",
                     rq.size(), r.idx, r.cyc - c0, r.data, r.ok);
        else pass_n++;
    endtask

    task automatic test_claim_sequence();
        int c0;
        ev_t r, w;
        ram_set(12'h010, EMPTY);
        @(negedge clk);
        clear_logs(); c0 = cyc;
        set_req(0, OP_CLAIM, 12'h010, 32'd3);
        run(5);
        r = at(rq, 0); w = at(wrq, 0);
        total_n++;
        if (rq.size() != 1 || r.idx != 0 || r.cyc - c0 != 3 ||
            r.data !== EMPTY || r.ok !== 1'b1)
            $display("FAIL claim1_rsp: got n=%0d idx=%0d cyc=%0d data=%h ok=%b want 1/0/3/ffffffff/1",
                     rq.size(), r.idx, r.cyc - c0, r.data, r.ok);
        else pass_n++;
        total_n++;
        if (wrq.size() != 1 || w.cyc - c0 != 2 || w.idx != 16 || w.data !== 32'd3)
            $display("FAIL claim1_write: got n=%0d cyc=%0d addr=%0d data=%h want 1/2/16/3",
                     wrq.size(), w.cyc - c0, w.idx, w.data);
        else pass_n++;
        total_n++;
        if (ram[16] !== 32'd3)
            $display("FAIL claim1_ram: got %h want 3", ram[16]);
        else pass_n++;
        @(negedge clk);
        clear_logs(); c0 = cyc;
        set_req(1, OP_CLAIM, 12'h010, 32'd9);
        run(5);
        r = at(rq, 0);
        total_n++;
        if (rq.size() != 1 || r.idx != 1 || r.cyc - c0 != 3 ||
            r.data !== 32'd3 || r.ok !== 1'b0)
            $display("FAIL claim2_rsp: got n=%0d idx=%0d cyc=%0d data=%h ok=%b want 1/1/3/3/0",
                     rq.size(), r.idx, r.cyc - c0, r.data, r.ok);
        else pass_n++;
        total_n++;
        if (wrq.size() != 0 || ram[16] !== 32'd3)
            $display("FAIL claim2_nowrite: got writes=%0d ram=%h want 0/3",
                     wrq.size(), ram[16]);
        else pass_n++;
    endtask

    task automatic test_reserved();
        int c0;
        ev_t g, r;
        @(negedge clk);
        clear_logs(); c0 = cyc;
        set_req(1, OP_RSVD, 12'h007, 32'h55);
        run(4);
        g = at(gq, 0); r = at(rq, 0);
        total_n++;
        if (gq.size() != 1 || g.idx != 1 || g.cyc - c0 != 1)
            $display("FAIL rsvd_grant: got n=%0d idx=%0d cyc=%0d want 1/1/1",
                     gq.size(), g.idx, g.cyc - c0);
        else pass_n++;
        total_n++;
        if (rq.size() != 1 || r.idx != 1 || r.cyc - c0 != 2 ||
            r.ok !== 1'b0 || r.data !== 32'd0)
            $display("FAIL rsvd_rsp: got n=%0d idx=%0d cyc=%0d data=%h ok=%b want 1/1/2/0/0",
                     rq.size(), r.idx, r.cyc - c0, r.data, r.ok);
        else pass_n++;
        total_n++;
        if (rdq.size() != 0 || wrq.size() != 0)
            $display("FAIL rsvd_nomem: got rd=%0d wr=%0d want 0/0",
                     rdq.size(), wrq.size());
        else pass_n++;
    endtask

    task automatic test_contended_claim();
        int c0;
        ev_t g, r;
        do_reset();
        ram_set(12'h020, EMPTY);
        @(negedge clk);
        clear_logs(); c0 = cyc;
        for (int i = 0; i < NREQ; i++) set_req(i, OP_CLAIM, 12'h020, 32'd10 + i);
        run(16);
        total_n++;
        if (gq.size() != NREQ || rq.size() != NREQ)
            $display("FAIL cont_count: got grants=%0d rsps=%0d want 4/4",
                     gq.size(), rq.size());
        else pass_n++;
        for (int i = 0; i < NREQ; i++) begin
            g = at(gq, i); r = at(rq, i);
            total_n++;
            if (g.idx != i || g.cyc - c0 != 1 + 3*i || r.idx != i ||
                r.cyc - c0 != 3 + 3*i || r.ok !== (i == 0) ||
                r.data !== ((i == 0) ? EMPTY : 32'd10))
                $display("FAIL cont_%0d: got g=%0d@%0d r=%0d@%0d ok=%b data=%h want %0d@%0d ok=%b",
                         i, g.idx, g.cyc - c0, r.idx, r.cyc - c0, r.ok, r.data,
                         i, 1 + 3*i, (i == 0));
            else pass_n++;
        end
        total_n++;
        if (ram[32] !== 32'd10 || wrq.size() != 1)
            $display("FAIL cont_ram: got ram=%h writes=%0d want a/1",
                     ram[32], wrq.size());
        else pass_n++;
    endtask

    task automatic test_fairness();
        int c0;
        ev_t g, r;
        do_reset();
        @(negedge clk);
        clear_logs(); c0 = cyc;
        set_req(1, OP_WRITE, 12'h040, 32'h111);
        set_req(3, OP_WRITE, 12'h041, 32'h333);
        repeat (12) @(negedge clk);
        req_valid = '0;
        run(3);
        total_n++;
        if (gq.size() != 6 || rq.size() != 6)
            $display("FAIL fair_count: got grants=%0d rsps=%0d want 6/6",
                     gq.size(), rq.size());
        else pass_n++;
        for (int k = 0; k < 6; k++) begin
            g = at(gq, k); r = at(rq, k);
            total_n++;
            if (g.idx != ((k % 2 == 0) ? 1 : 3) || g.cyc - c0 != 1 + 2*k ||
                r.idx != g.idx || r.cyc - c0 != 2 + 2*k || r.ok !== 1'b1)
                $display("FAIL fair_%0d: got g=%0d@%0d r=%0d@%0d ok=%b want %0d@%0d r@%0d",
                         k, g.idx, g.cyc - c0, r.idx, r.cyc - c0, r.ok,
                         (k % 2 == 0) ? 1 : 3, 1 + 2*k, 2 + 2*k);
            else pass_n++;
        end
    endtask

    task automatic test_reset_mid_claim();
        int c1;
        ev_t g;
        int bad;
        ram_set(12'h030, EMPTY);
        @(negedge clk);
        set_req(2, OP_CLAIM, 12'h030, 32'd77);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        total_n++;
        if (mem_write !== 1'b1)
            $display("FAIL mid_pending_write: got %b want 1", mem_write);
        else pass_n++;
        reset = 1'b1;
        #1;
        total_n++;
        if ({mem_write, mem_read, busy, rsp_valid, req_ready} !== '0)
            $display("FAIL mid_async_drop: got %b want 0",
                     {mem_write, mem_read, busy, rsp_valid, req_ready});
        else pass_n++;
        repeat (2) @(negedge clk);
        clear_logs(); c1 = cyc;
        set_req(0, OP_WRITE, 12'h031, 32'd5);
        set_req(3, OP_WRITE, 12'h032, 32'd6);
        reset = 1'b0;
        run(6);
        total_n++;
        if (ram[48] !== EMPTY)
            $display("FAIL mid_ram: got %h want ffffffff", ram[48]);
        else pass_n++;
        bad = 0;
        foreach (rq[k]) if (rq[k].idx == 2) bad++;
        total_n++;
        if (bad != 0)
            $display("FAIL mid_norsp: got %0d responses to 2 want 0", bad);
        else pass_n++;
        g = at(gq, 0);
        total_n++;
        if (gq.size() != 2 || g.idx != 0 || g.cyc - c1 != 1 || at(gq, 1).idx != 3)
            $display("FAIL mid_first_grant: got n=%0d first=%0d@%0d second=%0d want 2 0@1 3",
                     gq.size(), g.idx, g.cyc - c1, at(gq, 1).idx);
        else pass_n++;
    endtask

    task automatic test_random();
        int last;
        int busy_until;
        int exp_win;
        int j, lat, a;
        logic [1:0] op;
        logic [31:0] d, ed;
        logic eok, erd, ewr;
        logic [NREQ-1:0] pv;
        logic [NREQ-1:0] want_g;
        ev_t expq[$];
        ev_t e;
        do_reset();
        ram_clear();
        for (int i = 0; i < 4096; i++) mram[i] = EMPTY;
        last = NREQ - 1;
        busy_until = -1;
        pv = '0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            exp_win = -1;
            if (pv != '0 && cyc - 1 >= busy_until) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (last + k) % NREQ;
                    if (exp_win < 0 && pv[j]) exp_win = j;
                end
            end
            want_g = (exp_win < 0) ? '0 : (4'b0001 << exp_win);
            total_n++;
            if (req_ready !== want_g)
                $display("FAIL rand_grant@%0d: got %b want %b", cyc, req_ready, want_g);
            else pass_n++;
            if (exp_win >= 0) begin
                op = req_op[2*exp_win +: 2];
                a  = int'(req_addr[exp_win*ADDR_W +: ADDR_W]);
                d  = req_data[exp_win*DATA_W +: DATA_W];
                erd = 1'b0; ewr = 1'b0;
                case (op)
                    OP_READ:  begin ed = mram[a]; eok = 1'b1; lat = 2; erd = 1'b1; end
                    OP_WRITE: begin mram[a] = d; ed = '0; eok = 1'b1; lat = 1; ewr = 1'b1; end
                    OP_CLAIM: begin
                        ed = mram[a]; eok = (ed == EMPTY); lat = 2; erd = 1'b1;
                        if (eok) mram[a] = d;
                    end
                    default:  begin ed = '0; eok = 1'b0; lat = 1; end
                endcase
                expq.push_back('{cyc + lat, exp_win, ed, eok});
                busy_until = cyc + lat;
                last = exp_win;
                total_n++;
                if (mem_read !== erd || mem_write !== ewr ||
                    ((erd || ewr) && mem_addr !== a[11:0]) ||
                    (ewr && mem_wdata !== d))
                    $display("FAIL rand_strobe@%0d: got rd=%b wr=%b a=%h d=%h want rd=%b wr=%b a=%h d=%h",
                             cyc, mem_read, mem_write, mem_addr, mem_wdata, erd, ewr, a[11:0], d);
                else pass_n++;
                req_valid[exp_win] = 1'b0;
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                total_n++;
                if (rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data || rsp_ok !== e.ok)
                    $display("FAIL rand_rsp@%0d: got v=%b d=%h ok=%b want v=%b d=%h ok=%b",
                             cyc, rsp_valid, rsp_data, rsp_ok,
                             4'b0001 << e.idx, e.data, e.ok);
                else pass_n++;
            end else begin
                total_n++;
                if (rsp_valid !== '0)
                    $display("FAIL rand_spurious_rsp@%0d: got %b want 0", cyc, rsp_valid);
                else pass_n++;
            end
            total_n++;
            if (busy !== (cyc <= busy_until))
                $display("FAIL rand_busy@%0d: got %b want %b", cyc, busy, cyc <= busy_until);
            else pass_n++;
            if (t < 520) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        d = ($urandom_range(0, 3) == 0) ? EMPTY : $urandom;
                        set_req(i, 2'($urandom_range(0, 3)),
                                int'($urandom_range(0, 7)), d);
                    end
                end
            end
            pv = req_valid;
        end
        total_n++;
        if (expq.size() != 0 || req_valid !== '0)
            $display("FAIL rand_drain: got pending=%0d valid=%b want 0/0",
                     expq.size(), req_valid);
        else pass_n++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_claim_sequence();
        test_reserved();
        test_contended_claim();
        test_fairness();
        test_reset_mid_claim();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
